// File: rtl/mma_wb_pkg.sv
// rtl/mma_wb_pkg.sv - shared types and constants for the MMA destination writer
package mma_wb_pkg;

    typedef enum logic [2:0] {
        WB_IDLE,
        WB_CHECK,
        WB_WRITE,
        WB_DRAIN,
        WB_FINISH
    } wb_state_e;

    localparam logic [1:0] ICB_SIZE_WORD     = 2'b10;
    localparam int         WB_BYTES_PER_WORD = 4;
    localparam int         WB_ADDR_WIDTH     = 32;
    localparam int         WB_DATA_WIDTH     = 32;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0]     addr;
        logic [WB_DATA_WIDTH-1:0]     wdata;
        logic [WB_BYTES_PER_WORD-1:0] wmask;
    } wb_cmd_t;

    // Bus words needed to cover one row of tile_cols bytes (ceil(cols/4)).
    function automatic logic [15:0] wb_words_per_row(input logic [15:0] cols);
        return 16'(({1'b0, cols} + 17'd3) >> 2);
    endfunction

endpackage

// File: rtl/mma_wb_addr_gen.sv
// rtl/mma_wb_addr_gen.sv - row-major destination address walker for the writer
module mma_wb_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int ROW_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [15:0]           wpr,
    input  logic [ROW_W-1:0]      rows,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_in_row,
    output logic                  last_word
);

    logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [ROW_W-1:0]      row_idx_q,  row_idx_d;

    // Word offset is a shift of the word index; the row base is accumulated, never multiplied.
    assign addr        = row_addr_q + ADDR_WIDTH'({word_idx_q, 2'b00});
    assign last_in_row = (word_idx_q == wpr - 16'd1);
    assign last_word   = last_in_row && (row_idx_q == rows - ROW_W'(1));

    // Load the tile origin on init, otherwise advance one word per step with row wrap.
    always_comb begin
        row_addr_d = row_addr_q;
        word_idx_d = word_idx_q;
        row_idx_d  = row_idx_q;
        if (init) begin
            row_addr_d = base;
            word_idx_d = '0;
            row_idx_d  = '0;
        end else if (step) begin
            if (last_in_row) begin
                word_idx_d = '0;
                row_idx_d  = row_idx_q + ROW_W'(1);
                row_addr_d = row_addr_q + stride;
            end else begin
                word_idx_d = word_idx_q + 16'd1;
            end
        end
    end

    // Walker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_addr_q <= '0;
            word_idx_q <= '0;
            row_idx_q  <= '0;
        end else begin
            row_addr_q <= row_addr_d;
            word_idx_q <= word_idx_d;
            row_idx_q  <= row_idx_d;
        end
    end

endmodule

// File: rtl/mma_dst_writer.sv
// rtl/mma_dst_writer.sv - MMA result writeback to ICB; MMA_WB_ZERO_MASK_SKIP_EN drops zero-mask words
module mma_dst_writer
    import mma_wb_pkg::*;
#(
    parameter int BUS_WIDTH       = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int SIZE            = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    dst_base,
    input  logic [ADDR_WIDTH-1:0]    dst_row_stride_b,
    input  logic [$clog2(SIZE):0]    tile_rows,
    input  logic [15:0]              tile_cols,
    output logic                     busy,
    output logic                     done,
    output logic                     wr_err,
    input  logic                     fifo_output_valid,
    output logic                     fifo_output_ready,
    input  logic [3:0]               fifo_output_mask,
    input  logic [BUS_WIDTH-1:0]     fifo_output_data,
    output logic                     sa_icb_cmd_valid,
    input  logic                     sa_icb_cmd_ready,
    output logic [ADDR_WIDTH-1:0]    sa_icb_cmd_addr,
    output logic                     sa_icb_cmd_read,
    output logic [BUS_WIDTH-1:0]     sa_icb_cmd_wdata,
    output logic [3:0]               sa_icb_cmd_wmask,
    output logic [1:0]               sa_icb_cmd_size,
    input  logic                     sa_icb_rsp_valid,
    output logic                     sa_icb_rsp_ready,
    input  logic                     sa_icb_rsp_err
);

    localparam int ROW_W = $clog2(SIZE) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ROW_W-1:0]      rows_q, rows_d;
    logic [15:0]           cols_q, cols_d;
    logic                  wr_err_q, wr_err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cmd_valid_q, cmd_valid_d;
    wb_cmd_t               cmd_q, cmd_d;
    logic                  cmd_last_q, cmd_last_d;
    logic                  all_popped_q, all_popped_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic                  rsp_ready_q;

    logic                  gen_init, gen_step;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_last_in_row, gen_last_word;
    logic [15:0]           wpr;
    logic [OUT_W:0]        inflight;
    logic                  cmd_fire, pop_fire, rsp_spurious, cfg_bad, skip_word;

    assign wpr     = wb_words_per_row(cols_q);
    assign cfg_bad = (|base_q[1:0]) || (|stride_q[1:0]) || (rows_q == '0) || (cols_q == '0);

`ifdef MMA_WB_ZERO_MASK_SKIP_EN
    assign skip_word = (fifo_output_mask == 4'b0000);
`else
    assign skip_word = 1'b0;
`endif

    // The held command counts against the window before it handshakes so the limit is never exceeded.
    assign inflight          = {1'b0, outstanding_q} + {{OUT_W{1'b0}}, cmd_valid_q};
    assign fifo_output_ready = (state_q == WB_WRITE) && !all_popped_q
                             && (!cmd_valid_q || sa_icb_cmd_ready)
                             && (inflight < (OUT_W+1)'(MAX_OUTSTANDING));
    assign pop_fire          = fifo_output_ready && fifo_output_valid;
    assign cmd_fire          = cmd_valid_q && sa_icb_cmd_ready;
    assign rsp_spurious      = sa_icb_rsp_valid && (outstanding_q == '0);

    assign busy             = busy_q;
    assign done             = done_q;
    assign wr_err           = wr_err_q;
    assign sa_icb_cmd_valid = cmd_valid_q;
    assign sa_icb_cmd_addr  = ADDR_WIDTH'(cmd_q.addr);
    assign sa_icb_cmd_wdata = BUS_WIDTH'(cmd_q.wdata);
    assign sa_icb_cmd_wmask = cmd_q.wmask;
    assign sa_icb_cmd_read  = 1'b0;
    assign sa_icb_cmd_size  = ICB_SIZE_WORD;
    assign sa_icb_rsp_ready = rsp_ready_q;
    assign gen_init         = (state_q == WB_CHECK);
    assign gen_step         = pop_fire;

    mma_wb_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ROW_W      (ROW_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .init        (gen_init),
        .step        (gen_step),
        .base        (base_q),
        .stride      (stride_q),
        .wpr         (wpr),
        .rows        (rows_q),
        .addr        (gen_addr),
        .last_in_row (gen_last_in_row),
        .last_word   (gen_last_word)
    );

    // Responses retire one slot each; a response with nothing in flight is dropped.
    always_comb begin
        outstanding_d = outstanding_q + OUT_W'(cmd_fire)
                      - OUT_W'(sa_icb_rsp_valid && !rsp_spurious);
    end

    // Tile sequencing, command register loading and error collection.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        stride_d     = stride_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        wr_err_d     = wr_err_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_d        = cmd_q;
        cmd_last_d   = cmd_last_q;
        all_popped_d = all_popped_q;

        if (sa_icb_rsp_valid && (sa_icb_rsp_err || rsp_spurious)) begin
            wr_err_d = 1'b1;
        end
        if (cmd_fire) begin
            cmd_valid_d = 1'b0;
        end

        case (state_q)
            WB_IDLE: begin
                if (start) begin
                    base_d   = dst_base;
                    stride_d = dst_row_stride_b;
                    rows_d   = tile_rows;
                    cols_d   = tile_cols;
                    wr_err_d = 1'b0;
                    state_d  = WB_CHECK;
                end
            end
            WB_CHECK: begin
                all_popped_d = 1'b0;
                cmd_last_d   = 1'b0;
                if (cfg_bad) begin
                    wr_err_d = 1'b1;
                    state_d  = WB_FINISH;
                end else begin
                    state_d = WB_WRITE;
                end
            end
            WB_WRITE: begin
                if (cmd_fire && cmd_last_q) begin
                    state_d = WB_DRAIN;
                end
                if (pop_fire) begin
                    all_popped_d = gen_last_word;
                    if (skip_word) begin
                        if (gen_last_word) begin
                            state_d = WB_DRAIN;
                        end
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_d.addr  = WB_ADDR_WIDTH'(gen_addr);
                        cmd_d.wdata = WB_DATA_WIDTH'(fifo_output_data);
                        cmd_d.wmask = fifo_output_mask;
                        cmd_last_d  = gen_last_word;
                    end
                end
            end
            WB_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = WB_FINISH;
                end
            end
            WB_FINISH: begin
                state_d = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase

        busy_d = (state_d == WB_CHECK) || (state_d == WB_WRITE) || (state_d == WB_DRAIN);
        done_d = (state_d == WB_FINISH);
    end

    // All writer state; reset abandons any tile in progress without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WB_IDLE;
            base_q        <= '0;
            stride_q      <= '0;
            rows_q        <= '0;
            cols_q        <= '0;
            wr_err_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= '0;
            cmd_last_q    <= 1'b0;
            all_popped_q  <= 1'b0;
            outstanding_q <= '0;
            rsp_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            stride_q      <= stride_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            wr_err_q      <= wr_err_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_q         <= cmd_d;
            cmd_last_q    <= cmd_last_d;
            all_popped_q  <= all_popped_d;
            outstanding_q <= outstanding_d;
            rsp_ready_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mma_dst_writer.sv
// tb/tb_mma_dst_writer.sv - scoreboard bench for mma_dst_writer
module tb_mma_dst_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dst_base;
    logic [31:0] dst_row_stride_b;
    logic [4:0]  tile_rows;
    logic [15:0] tile_cols;
    logic        busy, done, wr_err;
    logic        fifo_output_valid, fifo_output_ready;
    logic [3:0]  fifo_output_mask;
    logic [31:0] fifo_output_data;
    logic        sa_icb_cmd_valid, sa_icb_cmd_ready;
    logic [31:0] sa_icb_cmd_addr;
    logic        sa_icb_cmd_read;
    logic [31:0] sa_icb_cmd_wdata;
    logic [3:0]  sa_icb_cmd_wmask;
    logic [1:0]  sa_icb_cmd_size;
    logic        sa_icb_rsp_valid, sa_icb_rsp_ready, sa_icb_rsp_err;

    always #5 clk = ~clk;

    mma_dst_writer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .dst_base          (dst_base),
        .dst_row_stride_b  (dst_row_stride_b),
        .tile_rows         (tile_rows),
        .tile_cols         (tile_cols),
        .busy              (busy),
        .done              (done),
        .wr_err            (wr_err),
        .fifo_output_valid (fifo_output_valid),
        .fifo_output_ready (fifo_output_ready),
        .fifo_output_mask  (fifo_output_mask),
        .fifo_output_data  (fifo_output_data),
        .sa_icb_cmd_valid  (sa_icb_cmd_valid),
        .sa_icb_cmd_ready  (sa_icb_cmd_ready),
        .sa_icb_cmd_addr   (sa_icb_cmd_addr),
        .sa_icb_cmd_read   (sa_icb_cmd_read),
        .sa_icb_cmd_wdata  (sa_icb_cmd_wdata),
        .sa_icb_cmd_wmask  (sa_icb_cmd_wmask),
        .sa_icb_cmd_size   (sa_icb_cmd_size),
        .sa_icb_rsp_valid  (sa_icb_rsp_valid),
        .sa_icb_rsp_ready  (sa_icb_rsp_ready),
        .sa_icb_rsp_err    (sa_icb_rsp_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } exp_t;

`ifdef MMA_WB_ZERO_MASK_SKIP_EN
    localparam int ZERO_TILE_CMDS = 2;
`else
    localparam int ZERO_TILE_CMDS = 3;
`endif

    exp_t        exp_q[$];
    logic [35:0] fifo_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int cmd_count   = 0;
    int rsp_count   = 0;
    int done_count  = 0;
    int rsp_owed    = 0;
    int rsp_credit  = 1000;
    int err_idx     = -1;
    int rsp_at_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        fifo_output_valid = (fifo_q.size() > 0);
        {fifo_output_data, fifo_output_mask} = (fifo_q.size() > 0) ? fifo_q[0] : 36'h0;
        sa_icb_rsp_valid = (rsp_owed > 0) && (rsp_credit > 0);
        sa_icb_rsp_err   = sa_icb_rsp_valid && (rsp_count == err_idx);
    endtask

    task automatic sample();
        @(negedge clk);
        if (sa_icb_rsp_valid && sa_icb_rsp_ready) begin
            rsp_owed--;
            rsp_count++;
            rsp_credit--;
        end
        if (sa_icb_cmd_valid && sa_icb_cmd_ready) begin
            exp_t e;
            cmd_count++;
            rsp_owed++;
            chk("cmd_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cmd_addr", sa_icb_cmd_addr, e.addr);
                chk("cmd_wdata", sa_icb_cmd_wdata, e.data);
                chk("cmd_wmask", sa_icb_cmd_wmask, e.mask);
            end
            chk("cmd_read", sa_icb_cmd_read, 0);
            chk("cmd_size", sa_icb_cmd_size, 2);
        end
        if (fifo_output_valid && fifo_output_ready && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        if (done) begin
            done_count++;
            rsp_at_done = rsp_count;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic load_tile(input logic [31:0] base, input logic [31:0] stride,
                             input int rows, input int cols, input int zero_idx);
        int wpr, tail;
        wpr  = (cols + 3) / 4;
        tail = cols % 4;
        for (int r = 0; r < rows; r++) begin
            for (int w = 0; w < wpr; w++) begin
                logic [31:0] data;
                logic [3:0]  mask;
                logic        skip;
                data = $urandom;
                mask = (w == wpr - 1 && tail != 0) ? 4'((1 << tail) - 1) : 4'hf;
                if (r * wpr + w == zero_idx) mask = 4'h0;
`ifdef MMA_WB_ZERO_MASK_SKIP_EN
                skip = (mask == 4'h0);
`else
                skip = 1'b0;
`endif
                fifo_q.push_back({data, mask});
                if (!skip) exp_q.push_back('{base + 32'(r) * stride + 32'(4 * w), data, mask});
            end
        end
        drive_inputs();
    endtask

    task automatic start_tile(input logic [31:0] base, input logic [31:0] stride,
                              input int rows, input int cols);
        dst_base         = base;
        dst_row_stride_b = stride;
        tile_rows        = 5'(rows);
        tile_cols        = 16'(cols);
        start            = 1'b1;
        tick();
        start            = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n, d0;
        n  = 0;
        d0 = done_count;
        while (done_count == d0 && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_done_once"}, 64'(done_count - d0), 64'd1);
    endtask

    task automatic finish_checks(input string tag, input int c0, input int r0,
                                 input int exp_cmds, input logic exp_err);
        wait_done(tag);
        chk({tag, "_cmds"}, 64'(cmd_count - c0), 64'(exp_cmds));
        chk({tag, "_rsp_before_done"}, 64'(rsp_at_done - r0), 64'(exp_cmds));
        chk({tag, "_wr_err"}, wr_err, exp_err);
        chk({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_fifo_drained"}, 64'(fifo_q.size()), 64'd0);
        sample();
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_done_after"}, done, 1'b0);
        advance();
        tick();
        chk({tag, "_single_done"}, 64'(done_count), 64'(done_count));
    endtask

    task automatic run_tile(input string tag, input logic [31:0] base, input logic [31:0] stride,
                            input int rows, input int cols, input int zero_idx,
                            input int exp_cmds, input logic exp_err);
        int c0, r0;
        c0 = cmd_count;
        r0 = rsp_count;
        load_tile(base, stride, rows, cols, zero_idx);
        start_tile(base, stride, rows, cols);
        finish_checks(tag, c0, r0, exp_cmds, exp_err);
    endtask

    task automatic err_tile(input string tag, input logic [31:0] base, input logic [31:0] stride,
                            input int rows, input int cols);
        int c0, r0;
        c0 = cmd_count;
        r0 = rsp_count;
        start_tile(base, stride, rows, cols);
        finish_checks(tag, c0, r0, 0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0, n;
        logic [31:0] snap_addr, snap_data;
        logic [3:0]  snap_mask;

        rst = 1'b1;
        start = 1'b0;
        dst_base = '0;
        dst_row_stride_b = '0;
        tile_rows = '0;
        tile_cols = '0;
        sa_icb_cmd_ready = 1'b1;
        drive_inputs();

        repeat (2) @(posedge clk);
        sample();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wr_err", wr_err, 1'b0);
        chk("rst_cmd_valid", sa_icb_cmd_valid, 1'b0);
        chk("rst_fifo_ready", fifo_output_ready, 1'b0);
        chk("rst_cmd_size", sa_icb_cmd_size, 2'b10);
        chk("rst_rsp_ready", sa_icb_rsp_ready, 1'b0);
        chk("rst_cmd_addr", sa_icb_cmd_addr, 32'h0);
        advance();
        rst = 1'b0;
        tick();
        chk("rsp_ready_after_rst", sa_icb_rsp_ready, 1'b1);

        run_tile("basic", 32'h2000_0000, 32'd16, 2, 8, -1, 4, 1'b0);
        run_tile("tail", 32'h2000_1000, 32'd32, 2, 6, -1, 4, 1'b0);

        // Back-pressure on the command channel in the middle of a tile.
        c0 = cmd_count;
        r0 = rsp_count;
        load_tile(32'h2000_2000, 32'd64, 2, 16, -1);
        start_tile(32'h2000_2000, 32'd64, 2, 16);
        n = 0;
        while (cmd_count - c0 < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("stall_reach", 64'(cmd_count - c0), 64'd2);
        sa_icb_cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("stall_cmd_valid", sa_icb_cmd_valid, 1'b1);
            chk("stall_fifo_ready", fifo_output_ready, 1'b0);
            if (i == 0) begin
                snap_addr = sa_icb_cmd_addr;
                snap_data = sa_icb_cmd_wdata;
                snap_mask = sa_icb_cmd_wmask;
            end else begin
                chk("stall_addr", sa_icb_cmd_addr, snap_addr);
                chk("stall_wdata", sa_icb_cmd_wdata, snap_data);
                chk("stall_wmask", sa_icb_cmd_wmask, snap_mask);
            end
            advance();
        end
        sa_icb_cmd_ready = 1'b1;
        finish_checks("stall", c0, r0, 8, 1'b0);

        // Outstanding window with responses withheld.
        c0 = cmd_count;
        r0 = rsp_count;
        rsp_credit = 0;
        load_tile(32'h2000_3000, 32'd4, 1, 32, -1);
        start_tile(32'h2000_3000, 32'd4, 1, 32);
        repeat (12) tick();
        sample();
        chk("window_cmds", 64'(cmd_count - c0), 64'd4);
        chk("window_fifo_ready", fifo_output_ready, 1'b0);
        chk("window_cmd_valid", sa_icb_cmd_valid, 1'b0);
        advance();
        rsp_credit = 1;
        drive_inputs();
        repeat (6) tick();
        chk("window_release_cmds", 64'(cmd_count - c0), 64'd5);
        chk("window_release_rsps", 64'(rsp_count - r0), 64'd1);
        rsp_credit = 1000;
        drive_inputs();
        finish_checks("window", c0, r0, 8, 1'b0);

        // Misaligned base: error, no traffic, done two cycles after start.
        c0 = cmd_count;
        dst_base = 32'h2000_0002;
        dst_row_stride_b = 32'd16;
        tile_rows = 5'd2;
        tile_cols = 16'd8;
        start = 1'b1;
        sample();
        advance();
        start = 1'b0;
        sample();
        chk("misalign_busy_c1", busy, 1'b1);
        chk("misalign_done_c1", done, 1'b0);
        advance();
        sample();
        chk("misalign_done_c2", done, 1'b1);
        chk("misalign_busy_c2", busy, 1'b0);
        chk("misalign_wr_err", wr_err, 1'b1);
        advance();
        sample();
        chk("misalign_done_c3", done, 1'b0);
        chk("misalign_no_cmds", 64'(cmd_count - c0), 64'd0);
        advance();

        err_tile("bad_stride", 32'h2000_4000, 32'd6, 1, 4);
        err_tile("zero_cols", 32'h2000_4000, 32'd16, 1, 0);
        err_tile("zero_rows", 32'h2000_4000, 32'd16, 0, 4);

        err_idx = rsp_count + 1;
        run_tile("rsp_err", 32'h2000_5000, 32'd16, 1, 12, -1, 3, 1'b1);
        err_idx = -1;
        run_tile("err_cleared", 32'h2000_5100, 32'd8, 1, 8, -1, 2, 1'b0);

        // Reset in the middle of a tile with three writes in flight.
        c0 = cmd_count;
        rsp_credit = 0;
        load_tile(32'h2000_6000, 32'd4, 1, 32, -1);
        start_tile(32'h2000_6000, 32'd4, 1, 32);
        n = 0;
        while (cmd_count - c0 < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("midrst_reach", 64'(cmd_count - c0), 64'd3);
        rst = 1'b1;
        #2;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_wr_err", wr_err, 1'b0);
        chk("midrst_cmd_valid", sa_icb_cmd_valid, 1'b0);
        chk("midrst_fifo_ready", fifo_output_ready, 1'b0);
        chk("midrst_cmd_size", sa_icb_cmd_size, 2'b10);
        chk("midrst_rsp_ready", sa_icb_rsp_ready, 1'b0);
        chk("midrst_cmd_wmask", sa_icb_cmd_wmask, 4'h0);
        fifo_q.delete();
        exp_q.delete();
        rsp_owed = 0;
        rsp_credit = 1000;
        drive_inputs();
        sample();
        advance();
        rst = 1'b0;
        tick();
        run_tile("after_rst", 32'h2000_7000, 32'd16, 2, 8, -1, 4, 1'b0);

        run_tile("zero_mask", 32'h2000_8000, 32'd16, 1, 12, 1, ZERO_TILE_CMDS, 1'b0);
        run_tile("zero_mask_last", 32'h2000_9000, 32'd16, 1, 8, 1, ZERO_TILE_CMDS - 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
